// File: rtl/prach_pkg.sv
// Shared types and constants for the PRACH U-plane datapath.
package prach_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned HDR_W  = 120;

  // Low byte of ecpriSeqid: E-bit set, subsequence number 0.
  localparam logic [7:0] ECPRI_SEQ_LSB = 8'h80;

  // ORAN U-plane sideband carried alongside each packet (first field is MSB).
  typedef struct packed {
    logic [15:0] size;
    logic [15:0] pc_id;
    logic [15:0] seq_id;
    logic        dataDirection;
    logic [2:0]  payloadVersion;
    logic [3:0]  filterIndex;
    logic [7:0]  frameId;
    logic [3:0]  subframeId;
    logic [5:0]  slotID;
    logic [5:0]  symbolid;
    logic [11:0] sectionId;
    logic        rb;
    logic        symInc;
    logic [9:0]  startPrb;
    logic [7:0]  numPrb;
    logic [7:0]  udCompHdr;
  } prach_uplane_hdr_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/prach_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo N.
module prach_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  // Scan farthest-to-nearest so the nearest requester after ptr is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      int unsigned idx;
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/prach_uplane_arbiter.sv
// Packet-level round-robin merge of N_SRC PRACH framer streams onto one U-plane TX port.
module prach_uplane_arbiter
  import prach_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter logic [7:0]  SEQ_INIT = 8'd0
) (
  input  logic                    clk_eth_xran,
  input  logic                    rst_eth_xran_n,
  input  logic [N_SRC*DATA_W-1:0] avst_sink_data,
  input  logic [N_SRC-1:0]        avst_sink_valid,
  input  logic [N_SRC-1:0]        avst_sink_startofpacket,
  input  logic [N_SRC-1:0]        avst_sink_endofpacket,
  output logic [N_SRC-1:0]        avst_sink_ready,
  input  logic [N_SRC*HDR_W-1:0]  sink_hdr,
  output logic [DATA_W-1:0]       avst_source_u_data,
  output logic                    avst_source_u_valid,
  output logic                    avst_source_u_startofpacket,
  output logic                    avst_source_u_endofpacket,
  input  logic                    avst_source_u_ready,
  output logic [15:0]             tx_u_size,
  output logic [15:0]             tx_u_pc_id,
  output logic [15:0]             tx_u_seq_id,
  output logic                    tx_u_dataDirection,
  output logic [2:0]              tx_u_payloadVersion,
  output logic [3:0]              tx_u_filterIndex,
  output logic [7:0]              tx_u_frameId,
  output logic [3:0]              tx_u_subframeId,
  output logic [5:0]              tx_u_slotID,
  output logic [5:0]              tx_u_symbolid,
  output logic [11:0]             tx_u_sectionId,
  output logic                    tx_u_rb,
  output logic                    tx_u_symInc,
  output logic [9:0]              tx_u_startPrb,
  output logic [7:0]              tx_u_numPrb,
  output logic [7:0]              tx_u_udCompHdr,
  output logic [2:0]              grant_id,
  output logic                    proto_err
);

  localparam int unsigned IW = 3;

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     rr_ptr;
  logic [7:0]        seq_cnt [N_SRC];
  prach_uplane_hdr_t hdr_q, win_hdr, new_hdr;
  logic [7:0]        win_seq;
  logic [N_SRC-1:0]  cand;
  logic [N_SRC-1:0]  stray;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic              grant_en, drop_seen, eop_xfer;
  logic [DATA_W-1:0] own_data;
  logic              own_valid, own_sop, own_eop;

  assign cand  = avst_sink_valid & avst_sink_startofpacket;
  assign stray = avst_sink_valid & ~avst_sink_startofpacket;

  prach_rr_pick #(.N(N_SRC), .IW(IW)) u_pick (
    .req       (cand),
    .ptr       (rr_ptr),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // Select the current owner's stream and the IDLE winner's header/sequence number.
  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_sop   = 1'b0;
    own_eop   = 1'b0;
    win_hdr   = '0;
    win_seq   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant_id == IW'(i)) begin
        own_data  = avst_sink_data[i*DATA_W +: DATA_W];
        own_valid = avst_sink_valid[i];
        own_sop   = avst_sink_startofpacket[i];
        own_eop   = avst_sink_endofpacket[i];
      end
      if (pick_idx == IW'(i)) begin
        win_hdr = sink_hdr[i*HDR_W +: HDR_W];
        win_seq = seq_cnt[i];
      end
    end
    // Upstream seq_id is replaced by the arbiter-owned counter.
    new_hdr        = win_hdr;
    new_hdr.seq_id = {win_seq, ECPRI_SEQ_LSB};
  end

  // State register.
  always_ff @(posedge clk_eth_xran) begin
    if (!rst_eth_xran_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Next state, pass-through muxing and handshake steering.
  always_comb begin
    state_d                     = state_q;
    avst_sink_ready             = '0;
    avst_source_u_data          = '0;
    avst_source_u_valid         = 1'b0;
    avst_source_u_startofpacket = 1'b0;
    avst_source_u_endofpacket   = 1'b0;
    grant_en                    = 1'b0;
    drop_seen                   = 1'b0;
    eop_xfer                    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_en = 1'b1;
          state_d  = BUSY;
        end else begin
          // Orphan mid-packet beats are flushed so they cannot block arbitration.
          avst_sink_ready = stray;
          drop_seen       = |stray;
        end
      end
      BUSY: begin
        avst_source_u_data          = own_data;
        avst_source_u_valid         = own_valid;
        avst_source_u_startofpacket = own_sop;
        avst_source_u_endofpacket   = own_eop;
        for (int unsigned i = 0; i < N_SRC; i++) begin
          if (grant_id == IW'(i)) avst_sink_ready[i] = avst_source_u_ready;
        end
        if (own_valid && avst_source_u_ready && own_eop) begin
          eop_xfer = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping, sideband latch, sequence counters and sticky error.
  always_ff @(posedge clk_eth_xran) begin
    if (!rst_eth_xran_n) begin
      grant_id  <= '0;
      rr_ptr    <= IW'(N_SRC - 1);
      hdr_q     <= '0;
      proto_err <= 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) seq_cnt[i] <= SEQ_INIT;
    end else begin
      if (grant_en) begin
        grant_id <= pick_idx;
        rr_ptr   <= pick_idx;
        hdr_q    <= new_hdr;
      end
      if (drop_seen) proto_err <= 1'b1;
      if (eop_xfer) begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
          if (grant_id == IW'(i)) seq_cnt[i] <= seq_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign tx_u_size           = hdr_q.size;
  assign tx_u_pc_id          = hdr_q.pc_id;
  assign tx_u_seq_id         = hdr_q.seq_id;
  assign tx_u_dataDirection  = hdr_q.dataDirection;
  assign tx_u_payloadVersion = hdr_q.payloadVersion;
  assign tx_u_filterIndex    = hdr_q.filterIndex;
  assign tx_u_frameId        = hdr_q.frameId;
  assign tx_u_subframeId     = hdr_q.subframeId;
  assign tx_u_slotID         = hdr_q.slotID;
  assign tx_u_symbolid       = hdr_q.symbolid;
  assign tx_u_sectionId      = hdr_q.sectionId;
  assign tx_u_rb             = hdr_q.rb;
  assign tx_u_symInc         = hdr_q.symInc;
  assign tx_u_startPrb       = hdr_q.startPrb;
  assign tx_u_numPrb         = hdr_q.numPrb;
  assign tx_u_udCompHdr      = hdr_q.udCompHdr;

endmodule

// File: tb/tb_prach_uplane_arbiter.sv
// Directed bench for prach_uplane_arbiter with a packet-level reference model.
module tb_prach_uplane_arbiter;
  import prach_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*128-1:0] sdata = '0;
  logic [N-1:0]   svalid = '0, ssop = '0, seop = '0;
  logic [N-1:0]   srdy;
  logic [N*120-1:0] shdr = '0;
  logic [127:0]   odata;
  logic           ovalid, osop, oeop;
  logic           src_ready = 1'b1;
  logic [15:0]    t_size, t_pc, t_seq;
  logic           t_dir, t_rb, t_syminc;
  logic [2:0]     t_pv, gid;
  logic [3:0]     t_fi, t_sf;
  logic [7:0]     t_fr, t_np, t_ud;
  logic [5:0]     t_sl, t_sy;
  logic [11:0]    t_sec;
  logic [9:0]     t_sp;
  logic           perr;

  prach_uplane_arbiter #(.N_SRC(N), .SEQ_INIT(8'd0)) dut (
    .clk_eth_xran(clk), .rst_eth_xran_n(rst_n),
    .avst_sink_data(sdata), .avst_sink_valid(svalid),
    .avst_sink_startofpacket(ssop), .avst_sink_endofpacket(seop),
    .avst_sink_ready(srdy), .sink_hdr(shdr),
    .avst_source_u_data(odata), .avst_source_u_valid(ovalid),
    .avst_source_u_startofpacket(osop), .avst_source_u_endofpacket(oeop),
    .avst_source_u_ready(src_ready),
    .tx_u_size(t_size), .tx_u_pc_id(t_pc), .tx_u_seq_id(t_seq),
    .tx_u_dataDirection(t_dir), .tx_u_payloadVersion(t_pv), .tx_u_filterIndex(t_fi),
    .tx_u_frameId(t_fr), .tx_u_subframeId(t_sf), .tx_u_slotID(t_sl), .tx_u_symbolid(t_sy),
    .tx_u_sectionId(t_sec), .tx_u_rb(t_rb), .tx_u_symInc(t_syminc), .tx_u_startPrb(t_sp),
    .tx_u_numPrb(t_np), .tx_u_udCompHdr(t_ud),
    .grant_id(gid), .proto_err(perr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- source drivers ----------------
  int                q_len [N][$];
  bit                q_nosop [N][$];
  prach_uplane_hdr_t q_hdr [N][$];
  bit  act [N];
  int  beat [N], plen [N], pktn [N];
  bit  nsp [N];
  bit  [N-1:0] hs = '0;
  bit  abort = 1'b0;
  bit  rdy_rand = 1'b0;

  task automatic push_pkt(input int s, input int len, input logic [15:0] pc, input bit nosop);
    prach_uplane_hdr_t h;
    h = prach_uplane_hdr_t'({$urandom, $urandom, $urandom, $urandom});
    h.size   = 16'(len * 16);
    h.pc_id  = pc;
    h.seq_id = 16'hDEAD;
    q_len[s].push_back(len);
    q_nosop[s].push_back(nosop);
    q_hdr[s].push_back(h);
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_rand) src_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) begin
      if (abort) begin
        act[i] = 1'b0;
        q_len[i].delete(); q_nosop[i].delete(); q_hdr[i].delete();
      end else begin
        if (act[i] && hs[i]) begin
          beat[i]++;
          if (beat[i] >= plen[i]) act[i] = 1'b0;
        end
        if (!act[i] && q_len[i].size() > 0) begin
          plen[i] = q_len[i].pop_front();
          nsp[i]  = q_nosop[i].pop_front();
          shdr[i*120 +: 120] = q_hdr[i].pop_front();
          beat[i] = 0;
          act[i]  = 1'b1;
          pktn[i]++;
        end
      end
      svalid[i] = act[i];
      ssop[i]   = act[i] && !nsp[i] && beat[i] == 0;
      seop[i]   = act[i] && !nsp[i] && beat[i] == plen[i] - 1;
      if (act[i] && hs[i] || act[i] && beat[i] == 0)
        sdata[i*128 +: 128] = {8'(i), 24'(pktn[i]), $urandom, $urandom, 32'(beat[i])};
    end
    abort = 1'b0;
  end

  // ---------------- reference model + compare ----------------
  bit          seen_rst = 1'b0;
  bit          m_busy, m_perr;
  int          m_own, m_last, m_grant;
  logic [7:0]  m_seq [N];
  logic [119:0] m_hdr;
  int          grant_log[$], seq_log[$], bsrc_log[$], bidx_log[$];

  always @(negedge clk) begin
    logic [N-1:0] e_rdy;
    bit e_valid;
    int w;
    prach_uplane_hdr_t h;
    hs = svalid & srdy;
    if (seen_rst) begin
      e_rdy = '0;
      e_valid = 1'b0;
      if (!m_busy) begin
        w = -1;
        for (int i = 0; i < N; i++) if (svalid[i] && ssop[i]) w = i;
        if (w < 0) e_rdy = svalid & ~ssop;
      end else begin
        e_valid = svalid[m_own];
        e_rdy[m_own] = src_ready;
      end
      chk("valid", 128'(ovalid), 128'(e_valid));
      chk("sink_ready", 128'(srdy), 128'(e_rdy));
      chk("grant_id", 128'(gid), 128'(m_grant));
      chk("proto_err", 128'(perr), 128'(m_perr));
      chk("sideband", 128'({t_size, t_pc, t_seq, t_dir, t_pv, t_fi, t_fr, t_sf, t_sl, t_sy,
                            t_sec, t_rb, t_syminc, t_sp, t_np, t_ud}), 128'(m_hdr));
      if (m_busy && e_valid) begin
        chk("data", odata, sdata[m_own*128 +: 128]);
        chk("sop_eop", 128'({osop, oeop}), 128'({ssop[m_own], seop[m_own]}));
        if (src_ready) begin
          if (osop) begin grant_log.push_back(int'(gid)); seq_log.push_back(int'(t_seq)); end
          bsrc_log.push_back(int'(odata[127:120]));
          bidx_log.push_back(int'(odata[31:0]));
        end
      end
    end
    // advance model to the state after the coming clock edge
    if (!rst_n) begin
      seen_rst = 1'b1;
      m_busy = 0; m_perr = 0; m_own = 0; m_last = N - 1; m_grant = 0; m_hdr = '0;
      for (int i = 0; i < N; i++) m_seq[i] = 8'd0;
    end else if (seen_rst && !m_busy) begin
      w = -1;
      for (int k = 1; k <= N && w < 0; k++)
        if (svalid[(m_last + k) % N] && ssop[(m_last + k) % N]) w = (m_last + k) % N;
      if (w >= 0) begin
        h = shdr[w*120 +: 120];
        h.seq_id = {m_seq[w], 8'h80};
        m_hdr = h; m_busy = 1; m_own = w; m_last = w; m_grant = w;
      end else if (|(svalid & ~ssop)) m_perr = 1;
    end else if (seen_rst && svalid[m_own] && src_ready && seop[m_own]) begin
      m_seq[m_own] = m_seq[m_own] + 8'd1;
      m_busy = 0;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic wait_idle(input int budget, input string nm);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #2;
      done = !m_busy;
      for (int i = 0; i < N; i++) if (act[i] || q_len[i].size() > 0) done = 0;
    end
    if (!done) begin n_fail++; $display("FAIL timeout_%s: got busy expected idle", nm); end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2; rst_n = 1'b0; abort = 1'b1;
    @(posedge clk); #2; rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); seq_log.delete(); bsrc_log.delete(); bidx_log.delete();
  endtask

  initial begin
    int k;
    int exp_grants[5];
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 128'(ovalid), 128'(0));
    chk("rst_ready", 128'(srdy), 128'(0));
    chk("rst_grant", 128'(gid), 128'(0));
    chk("rst_perr", 128'(perr), 128'(0));
    chk("rst_seq", 128'(t_seq), 128'(0));

    // single 4-beat packet from source 0
    @(posedge clk); #2;
    clear_logs();
    push_pkt(0, 4, 16'h0003, 0);
    wait_idle(100, "t1");
    chk("t1_pc_id", 128'(t_pc), 128'(16'h0003));
    chk("t1_seq_id", 128'(t_seq), 128'(16'h0080));
    chk("t1_grant", 128'(gid), 128'(0));
    chk("t1_beats", 128'(bidx_log.size()), 128'(4));

    // four sources all requesting, source 0 twice
    pulse_reset();
    clear_logs();
    push_pkt(0, 2, 16'h0100, 0); push_pkt(1, 2, 16'h0101, 0);
    push_pkt(2, 2, 16'h0102, 0); push_pkt(3, 2, 16'h0103, 0);
    push_pkt(0, 2, 16'h0200, 0);
    wait_idle(200, "t2");
    exp_grants = '{0, 1, 2, 3, 0};
    chk("t2_npkts", 128'(grant_log.size()), 128'(5));
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk("t2_order", 128'(grant_log[i]), 128'(exp_grants[i]));

    // 257 packets from source 2: sequence number wraps
    pulse_reset();
    clear_logs();
    for (int i = 0; i < 257; i++) push_pkt(2, 1, 16'h0200, 0);
    wait_idle(2000, "t3");
    chk("t3_npkts", 128'(seq_log.size()), 128'(257));
    for (int i = 0; i < 257 && i < seq_log.size(); i++)
      chk("t3_seq", 128'(seq_log[i]), 128'(((i % 256) << 8) | 'h80));
    if (seq_log.size() > 256) chk("t3_wrap", 128'(seq_log[256]), 128'(16'h0080));
    push_pkt(3, 1, 16'h0300, 0); push_pkt(0, 1, 16'h0000, 0);
    wait_idle(100, "t3b");
    chk("t3_other_n", 128'(seq_log.size()), 128'(259));
    if (seq_log.size() == 259) begin
      chk("t3_src3_seq", 128'(seq_log[257]), 128'(16'h0080));
      chk("t3_src0_seq", 128'(seq_log[258]), 128'(16'h0080));
    end

    // 8-beat packet under random backpressure, another source waiting
    clear_logs();
    rdy_rand = 1'b1;
    push_pkt(1, 8, 16'h0111, 0); push_pkt(3, 2, 16'h0333, 0);
    wait_idle(400, "t4");
    rdy_rand = 1'b0; src_ready = 1'b1;
    k = 0;
    for (int i = 0; i < bidx_log.size(); i++)
      if (bsrc_log[i] == 1) begin
        chk("t4_order", 128'(bidx_log[i]), 128'(k));
        k++;
      end
    chk("t4_count", 128'(k), 128'(8));
    chk("t4_first", 128'(grant_log.size() > 0 ? grant_log[0] : -1), 128'(1));

    // orphan beat from source 1 dropped, then a good packet
    clear_logs();
    push_pkt(1, 1, 16'h0000, 1); push_pkt(1, 3, 16'h0121, 0);
    wait_idle(100, "t5");
    chk("t5_perr", 128'(perr), 128'(1));
    chk("t5_npkts", 128'(grant_log.size()), 128'(1));
    chk("t5_beats", 128'(bidx_log.size()), 128'(3));
    chk("t5_pc_id", 128'(t_pc), 128'(16'h0121));

    // reset in the middle of a 6-beat packet
    clear_logs();
    push_pkt(0, 6, 16'h0600, 0);
    k = 0;
    while (k < 100 && !(act[0] && beat[0] == 2 && m_busy)) begin
      @(posedge clk); #2; k++;
    end
    if (k >= 100) begin n_fail++; $display("FAIL timeout_t6: got no beat 3 expected beat 3"); end
    rst_n = 1'b0; abort = 1'b1;
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    chk("t6_valid_after_rst", 128'(ovalid), 128'(0));
    chk("t6_perr_after_rst", 128'(perr), 128'(0));
    @(posedge clk); #2;
    clear_logs();
    push_pkt(3, 2, 16'h0630, 0); push_pkt(0, 2, 16'h0601, 0);
    wait_idle(100, "t6");
    chk("t6_npkts", 128'(grant_log.size()), 128'(2));
    if (grant_log.size() == 2) begin
      chk("t6_first", 128'(grant_log[0]), 128'(0));
      chk("t6_second", 128'(grant_log[1]), 128'(3));
      chk("t6_seq0", 128'(seq_log[0]), 128'(16'h0080));
      chk("t6_seq3", 128'(seq_log[1]), 128'(16'h0080));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
